apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_master_if.sv | 53 +++++
 rtl/apb_master.sv | 136 +++++++++++++
 tb/tb_apb_master.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_if.sv
// Command/response and APB bus signals between the apb_master block and its environment.
// Strobe signals exist only when APB_WSTRB_EN is defined.
interface apb_master_if #(
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned APB_ADDR_WIDTH = 32
);
  localparam int unsigned STRB_W = APB_DATA_WIDTH / 8;

  logic                      cmd_valid_in;
  logic                      cmd_ready_out;
  logic                      cmd_write_in;
  logic [APB_ADDR_WIDTH-1:0] cmd_addr_in;
  logic [APB_DATA_WIDTH-1:0] cmd_wdata_in;
  logic                      rsp_valid_out;
  logic                      rsp_ready_in;
  logic [APB_DATA_WIDTH-1:0] rsp_rdata_out;
  logic                      rsp_slverr_out;
  logic                      rsp_timeout_out;
  logic [APB_ADDR_WIDTH-1:0] apb_addr_out;
  logic                      apb_write_out;
  logic [APB_DATA_WIDTH-1:0] apb_wdata_out;
  logic                      apb_psel_out;
  logic                      apb_penable_out;
  logic [APB_DATA_WIDTH-1:0] apb_rdata_in;
  logic                      apb_ready_in;
  logic                      apb_slverr_in;
`ifdef APB_WSTRB_EN
  logic [STRB_W-1:0]         cmd_strb_in;
  logic [STRB_W-1:0]         apb_strb_out;
`endif

  modport master (
`ifdef APB_WSTRB_EN
    input  cmd_strb_in,
    output apb_strb_out,
`endif
    input  cmd_valid_in, cmd_write_in, cmd_addr_in, cmd_wdata_in, rsp_ready_in,
    input  apb_rdata_in, apb_ready_in, apb_slverr_in,
    output cmd_ready_out, rsp_valid_out, rsp_rdata_out, rsp_slverr_out, rsp_timeout_out,
    output apb_addr_out, apb_write_out, apb_wdata_out, apb_psel_out, apb_penable_out
  );

  modport slave (
`ifdef APB_WSTRB_EN
    output cmd_strb_in,
    input  apb_strb_out,
`endif
    output cmd_valid_in, cmd_write_in, cmd_addr_in, cmd_wdata_in, rsp_ready_in,
    output apb_rdata_in, apb_ready_in, apb_slverr_in,
    input  cmd_ready_out, rsp_valid_out, rsp_rdata_out, rsp_slverr_out, rsp_timeout_out,
    input  apb_addr_out, apb_write_out, apb_wdata_out, apb_psel_out, apb_penable_out
  );
endinterface

// File: rtl/apb_master.sv
// Single-transfer APB master: command in, one SETUP/ACCESS transfer with wait-state timeout, response out.
// Optional byte strobes are enabled by defining APB_WSTRB_EN.
module apb_master #(
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic          apb_clk_in,
  input logic          apb_rstn_in,
  apb_master_if.master bus
);
  localparam int unsigned STRB_W   = APB_DATA_WIDTH / 8;
  localparam int unsigned CNT_W    = 8;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE   = 4'b0001,
    S_SETUP  = 4'b0010,
    S_ACCESS = 4'b0100,
    S_RESP   = 4'b1000
  } state_e;

  state_e                    state_q;
  logic                      cmd_ready_q;
  logic                      psel_q;
  logic                      penable_q;
  logic                      write_q;
  logic [APB_ADDR_WIDTH-1:0] addr_q;
  logic [APB_DATA_WIDTH-1:0] wdata_q;
  logic                      rsp_valid_q;
  logic [APB_DATA_WIDTH-1:0] rsp_rdata_q;
  logic                      rsp_slverr_q;
  logic                      rsp_timeout_q;
  logic [CNT_W-1:0]          wait_cnt_q;

  // Transfer sequencing; every output below is a flop.
  always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
    if (!apb_rstn_in) begin
      state_q       <= S_IDLE;
      cmd_ready_q   <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      write_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
      wait_cnt_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_ready_q && bus.cmd_valid_in) begin
            write_q     <= bus.cmd_write_in;
            addr_q      <= bus.cmd_addr_in;
            wdata_q     <= bus.cmd_wdata_in;
            cmd_ready_q <= 1'b0;
            psel_q      <= 1'b1;
            penable_q   <= 1'b0;
            state_q     <= S_SETUP;
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        S_SETUP: begin
          penable_q  <= 1'b1;
          wait_cnt_q <= '0;
          state_q    <= S_ACCESS;
        end
        S_ACCESS: begin
          // A ready slave wins over an expiring counter in the same cycle.
          if (bus.apb_ready_in) begin
            rsp_rdata_q   <= write_q ? '0 : bus.apb_rdata_in;
            rsp_slverr_q  <= bus.apb_slverr_in;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            state_q       <= S_RESP;
          end else if (wait_cnt_q == WAIT_LAST) begin
            rsp_rdata_q   <= '0;
            rsp_slverr_q  <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_valid_q   <= 1'b1;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            state_q       <= S_RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
          end
        end
        S_RESP: begin
          if (bus.rsp_ready_in) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          cmd_ready_q <= 1'b0;
          psel_q      <= 1'b0;
          penable_q   <= 1'b0;
          rsp_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

`ifdef APB_WSTRB_EN
  logic [STRB_W-1:0] strb_q;

  // Strobes travel with the command and are frozen at accept.
  always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
    if (!apb_rstn_in) begin
      strb_q <= '0;
    end else if ((state_q == S_IDLE) && cmd_ready_q && bus.cmd_valid_in) begin
      strb_q <= bus.cmd_strb_in;
    end
  end

  assign bus.apb_strb_out = strb_q;
`endif

  assign bus.cmd_ready_out   = cmd_ready_q;
  assign bus.apb_psel_out    = psel_q;
  assign bus.apb_penable_out = penable_q;
  assign bus.apb_write_out   = write_q;
  assign bus.apb_addr_out    = addr_q;
  assign bus.apb_wdata_out   = wdata_q;
  assign bus.rsp_valid_out   = rsp_valid_q;
  assign bus.rsp_rdata_out   = rsp_rdata_q;
  assign bus.rsp_slverr_out  = rsp_slverr_q;
  assign bus.rsp_timeout_out = rsp_timeout_q;
endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: scripted APB slave, transfer-level expectation queue, per-cycle checker.
module tb_apb_master;
  localparam int TMO = 16;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          acc;
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } exp_t;

  logic clk;
  logic rstn;
  int   total;
  int   bad;

  exp_t expq[$];

  // Slave script for the current transfer.
  int          s_waits;
  logic        s_errw;
  logic        s_errr;
  logic [31:0] s_rdata;
  int          acc_seen;

  // Checker bookkeeping.
  int          psel_cnt;
  int          pen_cnt;
  int          rsp_cnt;
  int          last_psel;
  int          last_pen;
  logic [31:0] hold_addr;
  logic [31:0] hold_wdata;

  // Response as observed by the driving task.
  logic [31:0] r_rdata;
  logic        r_err;
  logic        r_tmo;

  apb_master_if #(.APB_DATA_WIDTH(32), .APB_ADDR_WIDTH(32)) bus ();

  apb_master #(
    .APB_DATA_WIDTH(32),
    .APB_ADDR_WIDTH(32),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .apb_clk_in (clk),
    .apb_rstn_in(rstn),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scripted slave: ready after s_waits stalled ACCESS cycles, junk data/error while stalled.
  always @(negedge clk) begin
    if (bus.apb_psel_out && bus.apb_penable_out) begin
      bus.apb_ready_in  = (acc_seen == s_waits);
      bus.apb_slverr_in = bus.apb_ready_in ? s_errr : s_errw;
      bus.apb_rdata_in  = bus.apb_ready_in ? s_rdata : (32'hBAD0_0000 ^ 32'(acc_seen));
      acc_seen++;
    end else begin
      acc_seen          = 0;
      bus.apb_ready_in  = 1'b0;
      bus.apb_slverr_in = s_errw;
      bus.apb_rdata_in  = 32'hFFFF_FFFF;
    end
  end

  // Per-cycle checker against the expected transfer at the head of the queue.
  always @(negedge clk) begin
    if (!rstn) begin
      expq.delete();
      psel_cnt   = 0;
      pen_cnt    = 0;
      rsp_cnt    = 0;
      hold_addr  = '0;
      hold_wdata = '0;
      chk("reset_ctrl", {58'd0, bus.apb_psel_out, bus.apb_penable_out, bus.apb_write_out,
          bus.cmd_ready_out, bus.rsp_valid_out, bus.rsp_slverr_out | bus.rsp_timeout_out}, 64'd0);
      chk("reset_addr_wdata", {bus.apb_addr_out, bus.apb_wdata_out}, 64'd0);
      chk("reset_rdata", 64'(bus.rsp_rdata_out), 64'd0);
    end else begin
      if (bus.apb_psel_out) begin
        if (expq.size() == 0) begin
          chk("unexpected_psel", 64'd1, 64'd0);
        end else begin
          chk("apb_addr", 64'(bus.apb_addr_out), 64'(expq[0].addr));
          chk("apb_wr_wdata", {31'd0, bus.apb_write_out, bus.apb_wdata_out},
              {31'd0, expq[0].wr, expq[0].wdata});
`ifdef APB_WSTRB_EN
          chk("apb_strb", 64'(bus.apb_strb_out), 64'(expq[0].strb));
`endif
          chk("setup_then_access", 64'(bus.apb_penable_out), 64'(psel_cnt > 0));
          chk("cmd_ready_busy", 64'(bus.cmd_ready_out), 64'd0);
          psel_cnt++;
          if (bus.apb_penable_out) pen_cnt++;
          if (psel_cnt > TMO + 2) chk("psel_overrun", 64'(psel_cnt), 64'(TMO + 1));
          hold_addr  = expq[0].addr;
          hold_wdata = expq[0].wdata;
        end
      end else begin
        chk("penable_wo_psel", 64'(bus.apb_penable_out), 64'd0);
        chk("hold_addr_wdata", {bus.apb_addr_out, bus.apb_wdata_out}, {hold_addr, hold_wdata});
      end

      if (bus.rsp_valid_out) begin
        if (expq.size() == 0) begin
          chk("unexpected_rsp", 64'd1, 64'd0);
        end else begin
          if (rsp_cnt == 0) begin
            chk("psel_cycles", 64'(psel_cnt), 64'(expq[0].acc + 1));
            chk("access_cycles", 64'(pen_cnt), 64'(expq[0].acc));
            last_psel = psel_cnt;
            last_pen  = pen_cnt;
          end
          chk("rsp_fields", {30'd0, bus.rsp_slverr_out, bus.rsp_timeout_out, bus.rsp_rdata_out},
              {30'd0, expq[0].err, expq[0].tmo, expq[0].rdata});
          chk("cmd_ready_rsp", 64'(bus.cmd_ready_out), 64'd0);
          rsp_cnt++;
        end
      end else if (rsp_cnt > 0) begin
        void'(expq.pop_front());
        psel_cnt = 0;
        pen_cnt  = 0;
        rsp_cnt  = 0;
      end
    end
  end

  function automatic exp_t mk_exp(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [3:0] strb, input int waits, input logic err_rdy,
                                  input logic [31:0] rdata);
    exp_t e;
    e.wr    = wr;
    e.addr  = addr;
    e.wdata = wdata;
    e.strb  = strb;
    e.tmo   = (waits >= TMO);
    e.acc   = e.tmo ? TMO : waits + 1;
    e.rdata = (wr || e.tmo) ? 32'd0 : rdata;
    e.err   = e.tmo ? 1'b1 : err_rdy;
    return e;
  endfunction

  task automatic drive_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb);
    bus.cmd_valid_in = 1'b1;
    bus.cmd_write_in = wr;
    bus.cmd_addr_in  = addr;
    bus.cmd_wdata_in = wdata;
`ifdef APB_WSTRB_EN
    bus.cmd_strb_in  = strb;
`else
    if (strb === 4'bxxxx) bus.cmd_wdata_in = wdata;
`endif
  endtask

  task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input int waits, input logic err_wait,
                         input logic err_rdy, input logic [31:0] rdata, input int hold,
                         input bit keep_valid);
    int n;
    expq.push_back(mk_exp(wr, addr, wdata, strb, waits, err_rdy, rdata));
    s_waits = waits;
    s_errw  = err_wait;
    s_errr  = err_rdy;
    s_rdata = rdata;
    drive_cmd(wr, addr, wdata, strb);
    n = 0;
    while (!bus.cmd_ready_out && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 64'(bus.cmd_ready_out), 64'd1);
    @(negedge clk);
    if (!keep_valid) bus.cmd_valid_in = 1'b0;
    n = 0;
    while (!bus.rsp_valid_out && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_timeout_wait", 64'(bus.rsp_valid_out), 64'd1);
    r_rdata = bus.rsp_rdata_out;
    r_err   = bus.rsp_slverr_out;
    r_tmo   = bus.rsp_timeout_out;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_no_accept", {62'd0, bus.cmd_ready_out, bus.rsp_valid_out}, 64'd1);
    end
    bus.rsp_ready_in = 1'b1;
    @(negedge clk);
    bus.rsp_ready_in = 1'b0;
    bus.cmd_valid_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    total = 0;
    bad   = 0;
    rstn  = 1'b0;
    s_waits = 0; s_errw = 1'b0; s_errr = 1'b0; s_rdata = '0; acc_seen = 0;
    last_psel = 0; last_pen = 0;
    bus.cmd_valid_in = 1'b0;
    bus.cmd_write_in = 1'b0;
    bus.cmd_addr_in  = '0;
    bus.cmd_wdata_in = '0;
    bus.rsp_ready_in = 1'b0;
    bus.apb_ready_in = 1'b0;
    bus.apb_slverr_in = 1'b0;
    bus.apb_rdata_in = '0;
`ifdef APB_WSTRB_EN
    bus.cmd_strb_in  = '0;
`endif
    repeat (3) @(negedge clk);
    #2 rstn = 1'b1;
    #1 chk("ready_before_edge", 64'(bus.cmd_ready_out), 64'd0);
    @(negedge clk);
    chk("ready_after_release", 64'(bus.cmd_ready_out), 64'd1);

    // Zero-wait read.
    do_xfer(1'b0, 32'hA030_0010, 32'h1111_2222, 4'hF, 0, 1'b0, 1'b0, 32'h0000_00C3, 0, 1'b0);
    chk("lit_read_rdata", 64'(r_rdata), 64'h0000_00C3);
    chk("lit_read_err", {62'd0, r_err, r_tmo}, 64'd0);
    chk("lit_read_psel", 64'(last_psel), 64'd2);
    chk("lit_read_pen", 64'(last_pen), 64'd1);

    // Write with three wait states.
    do_xfer(1'b1, 32'hA030_0004, 32'h0000_0F00, 4'hF, 3, 1'b0, 1'b0, 32'h5555_AAAA, 0, 1'b0);
    chk("lit_write_rdata", 64'(r_rdata), 64'd0);
    chk("lit_write_err", 64'(r_err), 64'd0);
    chk("lit_write_pen", 64'(last_pen), 64'd4);

    // Error asserted only while stalled, then error at ready.
    do_xfer(1'b0, 32'h0000_0100, 32'h0, 4'hF, 2, 1'b1, 1'b0, 32'h1234_5678, 0, 1'b0);
    chk("lit_err_wait_only", 64'(r_err), 64'd0);
    do_xfer(1'b0, 32'h0000_0104, 32'h0, 4'hF, 2, 1'b1, 1'b1, 32'h8765_4321, 0, 1'b0);
    chk("lit_err_at_ready", 64'(r_err), 64'd1);
    chk("lit_err_rdata", 64'(r_rdata), 64'h8765_4321);

    // Slave never ready.
    do_xfer(1'b0, 32'h0000_0200, 32'h0, 4'hF, 1000, 1'b0, 1'b0, 32'hCAFE_F00D, 0, 1'b0);
    chk("lit_tmo_flags", {30'd0, r_err, r_tmo, r_rdata}, {30'd0, 1'b1, 1'b1, 32'd0});
    chk("lit_tmo_pen", 64'(last_pen), 64'd16);

    // Ready on the last allowed ACCESS cycle is not a timeout.
    do_xfer(1'b0, 32'h0000_0300, 32'h0, 4'hF, 15, 1'b0, 1'b0, 32'h0BAD_CAFE, 0, 1'b0);
    chk("lit_last_cycle_ok", {63'd0, r_tmo}, 64'd0);
    chk("lit_last_cycle_pen", 64'(last_pen), 64'd16);

    // Response back-pressure with a new command already waiting.
    do_xfer(1'b1, 32'h0000_0400, 32'hDEAD_BEEF, 4'b0101, 1, 1'b0, 1'b0, 32'h0, 5, 1'b1);

    // Reset in the middle of ACCESS.
    expq.push_back(mk_exp(1'b0, 32'h0000_0500, 32'h0, 4'hF, 1000, 1'b0, 32'h0));
    s_waits = 1000;
    drive_cmd(1'b0, 32'h0000_0500, 32'h0, 4'hF);
    @(negedge clk);
    bus.cmd_valid_in = 1'b0;
    n = 0;
    while (!bus.apb_penable_out && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("reach_access", 64'(bus.apb_penable_out), 64'd1);
    repeat (2) @(negedge clk);
    #2 rstn = 1'b0;
    #1 chk("rst_async_psel", {62'd0, bus.apb_psel_out, bus.apb_penable_out}, 64'd0);
    chk("rst_async_rsp", 64'(bus.rsp_valid_out), 64'd0);
    repeat (2) @(negedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);
    chk("ready_after_midreset", {62'd0, bus.cmd_ready_out, bus.rsp_valid_out}, 64'd2);

    do_xfer(1'b0, 32'h0000_0600, 32'h0, 4'hF, 1, 1'b0, 1'b0, 32'h0000_5A5A, 0, 1'b0);
    chk("lit_after_reset", 64'(r_rdata), 64'h0000_5A5A);

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(expq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
